// File: rtl/wb_initiator.sv
// rtl/wb_initiator.sv - single-outstanding Wishbone pipelined master with retry and timeout
//
// Accepts one request at a time on a valid/ready handshake. It issues that request as one
// Wishbone pipelined cycle and returns a single-cycle response pulse.
//
// Ports:
//   clk_i, rst_n_i           clock, synchronous active-low reset
//   req_valid_i/req_ready_o  request handshake (ready only while idle)
//   req_we_i, req_adr_i, req_dat_i, req_sel_i   request fields, captured on accept
//   rsp_valid_o              one-cycle completion pulse
//   rsp_dat_o                read data (held; updated only by read ack/err)
//   rsp_err_o, rsp_tmo_o     error / timeout flags, valid with rsp_valid_o
//   wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o   Wishbone master outputs
//   wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i          Wishbone slave responses

module wb_initiator #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RETRY_MAX      = 3
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_adr_i,
    input  logic [31:0] req_dat_i,
    input  logic [3:0]  req_sel_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        rsp_tmo_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,
    input  logic        wb_stall_i,
    input  logic [31:0] wb_dat_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_BACKOFF,
        S_RESP
    } state_t;

    // The counter value in a cycle is the number of earlier bus-active cycles, so the
    // TIMEOUT_CYCLES-th active cycle is the one where it equals TIMEOUT_CYCLES-1.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RTY_LIM  = 4'(RETRY_MAX);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] tmo_cnt;
    logic [3:0]  rty_cnt;

    logic accept;
    logic bus_active;
    logic term_window;
    logic t_err;
    logic t_ack;
    logic t_rty;
    logic tmo_hit;
    logic rty_left;

    assign accept      = (state == S_IDLE) && req_valid_i;
    assign bus_active  = (state == S_ISSUE) || (state == S_WAIT);
    // A slave may only terminate a strobe it has accepted, or while we wait for it.
    assign term_window = ((state == S_ISSUE) && !wb_stall_i) || (state == S_WAIT);
    // Priority: err over ack over rty.
    assign t_err       = term_window && wb_err_i;
    assign t_ack       = term_window && !wb_err_i && wb_ack_i;
    assign t_rty       = term_window && !wb_err_i && !wb_ack_i && wb_rty_i;
    assign tmo_hit     = bus_active && (tmo_cnt == TMO_LAST);
    assign rty_left    = (rty_cnt < RTY_LIM);

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid_i) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE, S_WAIT: begin
                if (t_err || t_ack) begin
                    state_nxt = S_RESP;
                end else if (t_rty) begin
                    state_nxt = rty_left ? S_BACKOFF : S_RESP;
                end else if (tmo_hit) begin
                    state_nxt = S_RESP;
                end else if ((state == S_ISSUE) && !wb_stall_i) begin
                    state_nxt = S_WAIT;
                end
            end
            S_BACKOFF: state_nxt = S_ISSUE;
            S_RESP:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        req_ready_o = 1'b0;
        wb_cyc_o    = 1'b0;
        wb_stb_o    = 1'b0;
        rsp_valid_o = 1'b0;
        case (state)
            S_IDLE:  req_ready_o = 1'b1;
            S_ISSUE: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
            end
            S_WAIT:  wb_cyc_o    = 1'b1;
            S_RESP:  rsp_valid_o = 1'b1;
            default: ;
        endcase
    end

    // Captured request, counters and response registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wb_we_o   <= 1'b0;
            wb_adr_o  <= 32'd0;
            wb_sel_o  <= 4'd0;
            wb_dat_o  <= 32'd0;
            rsp_dat_o <= 32'd0;
            rsp_err_o <= 1'b0;
            rsp_tmo_o <= 1'b0;
            tmo_cnt   <= 16'd0;
            rty_cnt   <= 4'd0;
        end else begin
            if (accept) begin
                wb_we_o   <= req_we_i;
                wb_adr_o  <= req_adr_i;
                wb_sel_o  <= req_sel_i;
                wb_dat_o  <= req_dat_i;
                rsp_err_o <= 1'b0;
                rsp_tmo_o <= 1'b0;
                tmo_cnt   <= 16'd0;
                rty_cnt   <= 4'd0;
            end

            // Each re-issue gets a fresh timeout budget.
            if (state == S_BACKOFF) begin
                tmo_cnt <= 16'd0;
            end

            if (bus_active && (tmo_cnt != 16'hFFFF)) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end

            if (t_err) begin
                rsp_err_o <= 1'b1;
                if (!wb_we_o) begin
                    rsp_dat_o <= wb_dat_i;
                end
            end else if (t_ack) begin
                if (!wb_we_o) begin
                    rsp_dat_o <= wb_dat_i;
                end
            end else if (t_rty) begin
                if (rty_left) begin
                    rty_cnt <= rty_cnt + 4'd1;
                end else begin
                    rsp_err_o <= 1'b1;
                end
            end else if (tmo_hit) begin
                rsp_err_o <= 1'b1;
                rsp_tmo_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_initiator.sv
// tb/tb_wb_initiator.sv - self-checking bench for wb_initiator (TIMEOUT_CYCLES=8, RETRY_MAX=3)

module tb_wb_initiator;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_adr_i;
    logic [31:0] req_dat_i;
    logic [3:0]  req_sel_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        rsp_tmo_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_rty_i;
    logic        wb_stall_i;
    logic [31:0] wb_dat_i;

    always #5 clk = ~clk;

    wb_initiator #(
        .TIMEOUT_CYCLES(8),
        .RETRY_MAX     (3)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_we_i   (req_we_i),
        .req_adr_i  (req_adr_i),
        .req_dat_i  (req_dat_i),
        .req_sel_i  (req_sel_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_dat_o  (rsp_dat_o),
        .rsp_err_o  (rsp_err_o),
        .rsp_tmo_o  (rsp_tmo_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_sel_o   (wb_sel_o),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i),
        .wb_rty_i   (wb_rty_i),
        .wb_stall_i (wb_stall_i),
        .wb_dat_i   (wb_dat_i)
    );

    // kind: 0 no response, 1 ack, 2 err, 3 ack+err, 4 ack+rty (applied after n_rty retries)
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          stall;
        int          dly;
        int          n_rty;
        int          kind;
        logic [31:0] rdat;
        bit          late_ack;
        bit          hold;
        logic        exp_err;
        logic        exp_tmo;
        logic [31:0] exp_dat;
        int          exp_acc;
        int          exp_stb;
        int          exp_cyc;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];
    vec_t cur;
    vec_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int stall_left, dly_left, attempt;
    int lat, stb_n, cyc_n, acc_n, rsp_seen;
    bit lat_on;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave model plus response monitor, evaluated on the falling edge.
    task automatic bus_model();
        logic acc_now;
        logic term;
        vec_t e;
        forever begin
            @(negedge clk);
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_stall_i = 1'b0;
            wb_dat_i = cur.rdat;
            term = 1'b0;
            acc_now = rst_n_i && req_valid_i && (req_ready_o === 1'b1);
            if (acc_now) attempt = 0;
            if (wb_cyc_o === 1'b1 && wb_stb_o === 1'b1) begin
                if (stall_left > 0) begin
                    wb_stall_i = 1'b1;
                    stall_left--;
                end else begin
                    dly_left = cur.dly;
                    term = (dly_left == 0);
                end
            end else if (wb_cyc_o === 1'b1) begin
                if (dly_left > 0) dly_left--;
                term = (dly_left == 0);
            end else begin
                stall_left = cur.stall;
                if (cur.late_ack) wb_ack_i = 1'b1;
            end
            if (term) begin
                if (attempt < cur.n_rty) begin
                    wb_rty_i = 1'b1;
                    attempt++;
                end else begin
                    case (cur.kind)
                        1: wb_ack_i = 1'b1;
                        2: wb_err_i = 1'b1;
                        3: begin wb_ack_i = 1'b1; wb_err_i = 1'b1; end
                        4: begin wb_ack_i = 1'b1; wb_rty_i = 1'b1; end
                        default: ;
                    endcase
                end
            end

            if (acc_now) begin
                lat = 1; lat_on = 1'b1; stb_n = 0; cyc_n = 0; acc_n = 0;
            end else if (lat_on) begin
                lat++;
            end
            if (wb_stb_o === 1'b1) begin
                stb_n++;
                if (!wb_stall_i) begin
                    acc_n++;
                    chk("bus fields", {27'd0, wb_we_o, wb_sel_o}, {27'd0, cur.we, cur.sel});
                    chk("bus adr", wb_adr_o, cur.adr);
                    chk("bus wdat", wb_dat_o, cur.dat);
                end
            end
            if (wb_cyc_o === 1'b1) cyc_n++;
            if (rsp_valid_o === 1'b1) begin
                rsp_seen++;
                lat_on = 1'b0;
                if (sb.size() == 0) begin
                    chk("unexpected rsp_valid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_err", rsp_err_o, e.exp_err);
                    chk("rsp_tmo", rsp_tmo_o, e.exp_tmo);
                    chk("rsp_dat", rsp_dat_o, e.exp_dat);
                    chk("stb accepts", acc_n, e.exp_acc);
                    chk("stb cycles", stb_n, e.exp_stb);
                    chk("cyc cycles", cyc_n, e.exp_cyc);
                    chk("latency", lat, e.exp_lat);
                end
            end
        end
    endtask

    task automatic issue_req(input vec_t v);
        cur = v;
        for (int i = 0; i < 20 && req_ready_o !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        chk("ready before issue", req_ready_o, 1);
        req_we_i = v.we; req_adr_i = v.adr; req_dat_i = v.dat; req_sel_i = v.sel;
        req_valid_i = 1'b1;
        @(posedge clk); #1;
        if (v.hold) begin
            req_we_i = ~v.we; req_adr_i = ~v.adr; req_dat_i = ~v.dat; req_sel_i = ~v.sel;
            repeat (2) begin @(posedge clk); #1; end
        end
        req_valid_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        sb.push_back(v);
        issue_req(v);
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("response arrived", sb.size(), 0);
        sb.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t v;
        int seen0;
        //            we    adr           dat           sel   st dly rty k rdat          la hold err  tmo  exp_dat       acc stb cyc lat
        vecs[0] = '{1'b0, 32'h0000_0004, 32'h0,        4'hF, 0,  0, 0, 1, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1, 1, 1, 3};
        vecs[1] = '{1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, 3,  2, 0, 1, 32'h5555_5555, 0, 1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1, 4, 6, 8};
        vecs[2] = '{1'b0, 32'h0000_0020, 32'h0,        4'h3, 0,  0, 4, 1, 32'h1111_1111, 0, 0, 1'b1, 1'b0, 32'hDEAD_BEEF, 4, 4, 4, 9};
        vecs[3] = '{1'b0, 32'h0000_0030, 32'h0,        4'hF, 0,  0, 0, 0, 32'h2222_2222, 0, 0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1, 1, 8, 10};
        vecs[4] = '{1'b0, 32'h0000_0040, 32'h0,        4'hF, 0,  0, 0, 3, 32'hCAFE_F00D, 0, 0, 1'b1, 1'b0, 32'hCAFE_F00D, 1, 1, 1, 3};
        vecs[5] = '{1'b0, 32'h0000_0044, 32'h0,        4'hF, 0,  7, 0, 1, 32'h0BAD_F00D, 0, 0, 1'b0, 1'b0, 32'h0BAD_F00D, 1, 1, 8, 10};
        vecs[6] = '{1'b0, 32'h0000_0048, 32'h0,        4'hC, 2,  1, 0, 2, 32'h3333_3333, 0, 0, 1'b1, 1'b0, 32'h3333_3333, 1, 3, 4, 6};
        vecs[7] = '{1'b0, 32'h0000_004C, 32'h0,        4'hF, 0,  0, 0, 4, 32'h4444_4444, 0, 0, 1'b0, 1'b0, 32'h4444_4444, 1, 1, 1, 3};
        vecs[8] = '{1'b1, 32'h0000_0050, 32'hA5A5_A5A5, 4'h1, 0,  0, 1, 1, 32'h6666_6666, 0, 0, 1'b0, 1'b0, 32'h4444_4444, 2, 2, 2, 5};
        vecs[9] = '{1'b0, 32'h0000_0054, 32'h0,        4'hF, 20, 0, 0, 1, 32'h7777_7777, 0, 0, 1'b1, 1'b1, 32'h4444_4444, 0, 8, 8, 10};

        cur = vecs[0];
        cur.kind = 0;
        stall_left = 0; dly_left = 0; attempt = 0;
        lat = 0; stb_n = 0; cyc_n = 0; acc_n = 0; rsp_seen = 0; lat_on = 1'b0;
        rst_n_i = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0;
        req_adr_i = 32'h0; req_dat_i = 32'h0; req_sel_i = 4'h0;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_stall_i = 1'b0; wb_dat_i = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst cyc/stb/we", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 0);
        chk("rst adr", wb_adr_o, 0);
        chk("rst wdat", wb_dat_o, 0);
        chk("rst sel", wb_sel_o, 0);
        chk("rst rsp flags", {29'd0, rsp_valid_o, rsp_err_o, rsp_tmo_o}, 0);
        chk("rst rsp_dat", rsp_dat_o, 0);
        rst_n_i = 1'b1;
        fork
            bus_model();
        join_none
        @(posedge clk); #1;
        chk("ready after release", req_ready_o, 1);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        // Ack arriving after a timeout, and while idle, is ignored.
        v = vecs[3];
        v.adr = 32'h0000_0060;
        v.late_ack = 1'b1;
        v.exp_dat = 32'h4444_4444;
        run_vec(v);
        seen0 = rsp_seen;
        repeat (3) begin @(posedge clk); #1; end
        chk("late ack no cyc", wb_cyc_o, 0);
        chk("late ack idle", req_ready_o, 1);
        chk("late ack no rsp", rsp_seen, seen0);

        // Reset pulse while waiting for the slave aborts the transaction.
        v = vecs[0];
        v.adr = 32'h0000_0070;
        v.dly = 10;
        issue_req(v);
        for (int i = 0; i < 30 && !(wb_cyc_o === 1'b1 && wb_stb_o === 1'b0); i++) begin
            @(posedge clk); #1;
        end
        chk("reached WAIT", {30'd0, wb_cyc_o, wb_stb_o}, 2);
        seen0 = rsp_seen;
        rst_n_i = 1'b0;
        @(posedge clk); #1;
        chk("abort cyc/stb", {30'd0, wb_cyc_o, wb_stb_o}, 0);
        rst_n_i = 1'b1;
        @(posedge clk); #1;
        chk("abort ready", req_ready_o, 1);
        repeat (12) begin @(posedge clk); #1; end
        chk("abort no rsp", rsp_seen, seen0);

        // Normal operation after the abort.
        v = vecs[0];
        v.adr = 32'h0000_0008;
        v.rdat = 32'h89AB_CDEF;
        v.exp_dat = 32'h89AB_CDEF;
        run_vec(v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
